// File: rtl/mips_cpu_core.sv
// Single-cycle MIPS subset core: fetch, decode, execute, memory and writeback in one clock.
// Latency: one instruction retires per rising clock edge (PC, register and memory commit together).
// Backpressure: none; the core free-runs whenever reset is high and is frozen while reset is low.

// 32x32 register file, two async read ports, one sync write port, $0 reads as zero.
// Latency: reads combinational, write visible after the rising edge.
// Backpressure: none.
module mips_regfile (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] data [0:31];

  // async reads; $0 is forced to zero regardless of what the array holds
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : data[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : data[ra2];
  end

  // sync write; writes aimed at $0 are dropped
  always @(posedge clock) begin
    if (we && (wa != 5'd0)) data[wa] <= wd;
  end
endmodule

// Unified word-addressed program/data memory, one fetch port and one data port.
// Latency: reads combinational, write visible after the rising edge.
// Backpressure: none.
module mips_memory #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic [AW-1:0] iaddr,
  output logic [31:0]   instr,
  input  logic [AW-1:0] daddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [31:0]   wdata
);
  logic [31:0] data [0:MEM_WORDS-1];

  // async fetch and load reads; a store is only seen by the next cycle's reads
  always_comb begin
    instr = data[iaddr];
    rdata = data[daddr];
  end

  // sync store port
  always @(posedge clock) begin
    if (we) data[daddr] <= wdata;
  end
endmodule

// Datapath: PC, decode, ALU, branch/jump resolution, register file and memory.
// Latency: single cycle per instruction.
// Backpressure: none; architectural writes are suppressed while reset is low.
module mips_datapath #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic clock,
  input  logic reset
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;

  logic [31:0] pc, pc_plus4, pc_next, instr;
  logic [31:0] rs_val, rt_val, rdata;
  logic [31:0] imm_sext, imm_zext, addr_sum, br_target, j_target, reg_wd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, reg_wa;
  logic        reg_we, mem_we;

  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext  = {16'd0, instr[15:0]};
  assign pc_plus4  = pc + 32'd4;
  assign addr_sum  = rs_val + imm_sext;
  assign br_target = pc_plus4 + (imm_sext << 2);
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

  mips_regfile RegFile_0 (
    .clock (clock),
    .we    (reg_we & reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (reg_wa),
    .wd    (reg_wd),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  mips_memory #(.MEM_WORDS(MEM_WORDS)) Memory_0 (
    .clock (clock),
    .iaddr (pc[AW+1:2]),
    .instr (instr),
    .daddr (addr_sum[AW+1:2]),
    .rdata (rdata),
    .we    (mem_we & reset),
    .wdata (rt_val)
  );

  // decode/execute: pick writeback target and value, store enable and next PC
  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rd;
    reg_wd  = 32'd0;
    mem_we  = 1'b0;
    pc_next = pc_plus4;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          F_ADD:   reg_wd = rs_val + rt_val;
          F_SUB:   reg_wd = rs_val - rt_val;
          F_AND:   reg_wd = rs_val & rt_val;
          F_OR:    reg_wd = rs_val | rt_val;
          F_NOR:   reg_wd = ~(rs_val | rt_val);
          F_SLT:   reg_wd = {31'd0, ($signed(rs_val) < $signed(rt_val))};
          F_SLL:   reg_wd = rt_val << shamt;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin reg_we = 1'b1; reg_wa = rt; reg_wd = addr_sum;          end
      OP_ANDI: begin reg_we = 1'b1; reg_wa = rt; reg_wd = rs_val & imm_zext; end
      OP_ORI:  begin reg_we = 1'b1; reg_wa = rt; reg_wd = rs_val | imm_zext; end
      OP_LW:   begin reg_we = 1'b1; reg_wa = rt; reg_wd = rdata;             end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_next = br_target;
      OP_BNE:  if (rs_val != rt_val) pc_next = br_target;
      OP_J:    pc_next = j_target;
      default: ;
    endcase
  end

  // PC register; reset pulls it to RESET_PC without waiting for a clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end
endmodule

// Top-level CPU: wraps the datapath; clock and reset are the only ports.
// Latency: one instruction per rising edge.
// Backpressure: none.
module mips_cpu_core #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic clock,
  input  logic reset
);
  mips_datapath #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) DataPath_0 (
    .clock (clock),
    .reset (reset)
  );
endmodule

// File: tb/tb_mips_cpu_core.sv
module tb_mips_cpu_core;
  localparam int          MEM_WORDS = 256;
  localparam logic [31:0] RESET_PC  = 32'd0;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  // architectural reference state
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:MEM_WORDS-1];
  logic [31:0] m_pc;

  mips_cpu_core #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm, off;
    logic [31:0] w;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    sh  = 5'($urandom);
    imm = 16'($urandom);
    off = 16'(int'($urandom_range(0, 15)) - 8);
    case ($urandom_range(0, 15))
      0:  w = r_ins(rs, rt, rd, sh, 6'h20);
      1:  w = r_ins(rs, rt, rd, sh, 6'h22);
      2:  w = r_ins(rs, rt, rd, sh, 6'h24);
      3:  w = r_ins(rs, rt, rd, sh, 6'h25);
      4:  w = r_ins(rs, rt, rd, sh, 6'h27);
      5:  w = r_ins(rs, rt, rd, sh, 6'h2A);
      6:  w = r_ins(rs, rt, rd, sh, 6'h00);
      7:  w = i_ins(6'h08, rs, rt, imm);
      8:  w = i_ins(6'h0C, rs, rt, imm);
      9:  w = i_ins(6'h0D, rs, rt, imm);
      10: w = i_ins(6'h23, rs, rt, imm);
      11: w = i_ins(6'h2B, rs, rt, imm);
      12: w = i_ins(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, off);
      13: w = i_ins(6'h05, rs, ($urandom_range(0, 1) == 1) ? rs : rt, off);
      14: w = j_ins(26'($urandom_range(0, MEM_WORDS - 1)));
      default: w = ($urandom_range(0, 1) == 1) ? i_ins(6'h3F, rs, rt, imm)
                                               : r_ins(rs, rt, rd, sh, 6'h01);
    endcase
    return w;
  endfunction

  // execute one instruction against the reference state, straight from the ISA rules
  task automatic model_step();
    logic [31:0] ins, a, b, sx, zx, res, npc;
    int unsigned widx;
    int          dest;
    bit          wr;
    ins  = m_mem[(m_pc >> 2) % MEM_WORDS];
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    sx   = 32'($signed(ins[15:0]));
    zx   = 32'(ins[15:0]);
    widx = ((a + sx) >> 2) % MEM_WORDS;
    npc  = m_pc + 32'd4;
    wr   = 1'b0;
    dest = ins[20:16];
    res  = 32'd0;
    case (ins[31:26])
      6'h00: begin
        dest = ins[15:11];
        wr   = 1'b1;
        case (ins[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << ins[10:6];
          default: wr = 1'b0;
        endcase
      end
      6'h08: begin wr = 1'b1; res = a + sx; end
      6'h0C: begin wr = 1'b1; res = a & zx; end
      6'h0D: begin wr = 1'b1; res = a | zx; end
      6'h23: begin wr = 1'b1; res = m_mem[widx]; end
      6'h2B: m_mem[widx] = b;
      6'h04: if (a == b) npc = m_pc + 32'd4 + sx * 4;
      6'h05: if (a != b) npc = m_pc + 32'd4 + sx * 4;
      6'h02: npc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) * 4);
      default: ;
    endcase
    if (wr && dest != 0) m_reg[dest] = res;
    m_pc = npc;
  endtask

  task automatic init_model();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'd0;
    m_pc = RESET_PC;
  endtask

  task automatic push_to_dut();
    for (int i = 0; i < 32; i++) dut.DataPath_0.RegFile_0.data[i] = m_reg[i];
    for (int i = 0; i < MEM_WORDS; i++) dut.DataPath_0.Memory_0.data[i] = m_mem[i];
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    init_model();
    m_mem[0] = r_ins(5'd1, 5'd1, 5'd3, 5'd0, 6'h20);
    push_to_dut();
    repeat (3) @(negedge clock);
    checks++;
    if (dut.DataPath_0.pc !== RESET_PC) begin
      errors++; $display("FAIL reset_pc: got %h want %h", dut.DataPath_0.pc, RESET_PC);
    end
    checks++;
    if (dut.DataPath_0.RegFile_0.data[3] !== 32'd3) begin
      errors++; $display("FAIL reset_no_regwrite: got %h want %h", dut.DataPath_0.RegFile_0.data[3], 32'd3);
    end
  endtask

  task automatic test_directed();
    logic [31:0] got, want;
    string       nm;
    bit          have;
    init_model();
    m_mem[0]  = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    m_mem[1]  = r_ins(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
    m_mem[2]  = i_ins(6'h04, 5'd1, 5'd1, 16'd2);
    m_mem[3]  = r_ins(5'd1, 5'd1, 5'd20, 5'd0, 6'h20);
    m_mem[4]  = r_ins(5'd1, 5'd1, 5'd20, 5'd0, 6'h20);
    m_mem[5]  = r_ins(5'd6, 5'd7, 5'd5, 5'd0, 6'h24);
    m_mem[6]  = r_ins(5'd9, 5'd10, 5'd8, 5'd0, 6'h25);
    m_mem[7]  = r_ins(5'd2, 5'd1, 5'd11, 5'd0, 6'h2A);
    m_mem[8]  = r_ins(5'd1, 5'd2, 5'd11, 5'd0, 6'h2A);
    m_mem[9]  = i_ins(6'h2B, 5'd0, 5'd7, 16'd0);
    m_mem[10] = i_ins(6'h23, 5'd0, 5'd12, 16'd0);
    m_mem[11] = i_ins(6'h08, 5'd5, 5'd13, 16'hFFFA);
    m_mem[12] = i_ins(6'h05, 5'd1, 5'd1, 16'd2);
    m_mem[13] = r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h20);
    m_mem[14] = i_ins(6'h3F, 5'd1, 5'd2, 16'h1800);
    m_mem[15] = j_ins(26'h14);
    m_mem[16] = i_ins(6'h0D, 5'd0, 5'd14, 16'h1234);
    m_mem[17] = r_ins(5'd0, 5'd3, 5'd15, 5'd4, 6'h00);
    m_mem[18] = r_ins(5'd0, 5'd0, 5'd16, 5'd0, 6'h27);
    m_mem[19] = i_ins(6'h0C, 5'd16, 5'd17, 16'h00F0);
    m_mem[20] = j_ins(26'h10);
    @(negedge clock);
    reset = 1'b0;
    push_to_dut();
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if (dut.DataPath_0.pc !== m_pc) begin
        errors++; $display("FAIL dir_pc step %0d: got %h want %h", k, dut.DataPath_0.pc, m_pc);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (dut.DataPath_0.RegFile_0.data[i] !== m_reg[i]) begin
          errors++; $display("FAIL dir_reg step %0d r%0d: got %h want %h", k, i, dut.DataPath_0.RegFile_0.data[i], m_reg[i]);
        end
      end
      have = 1'b1; nm = ""; got = 32'd0; want = 32'd0;
      case (k)
        1:  begin nm = "add";      got = dut.DataPath_0.RegFile_0.data[3];  want = 32'd3;         end
        2:  begin nm = "sub";      got = dut.DataPath_0.RegFile_0.data[4];  want = 32'hFFFF_FFFF; end
        3:  begin nm = "beq_pc";   got = dut.DataPath_0.pc;                 want = 32'd20;        end
        4:  begin nm = "and";      got = dut.DataPath_0.RegFile_0.data[5];  want = 32'd6;         end
        5:  begin nm = "or";       got = dut.DataPath_0.RegFile_0.data[8];  want = 32'd11;        end
        6:  begin nm = "slt0";     got = dut.DataPath_0.RegFile_0.data[11]; want = 32'd0;         end
        7:  begin nm = "slt1";     got = dut.DataPath_0.RegFile_0.data[11]; want = 32'd1;         end
        8:  begin nm = "sw";       got = dut.DataPath_0.Memory_0.data[0];   want = 32'd7;         end
        9:  begin nm = "lw";       got = dut.DataPath_0.RegFile_0.data[12]; want = 32'd7;         end
        10: begin nm = "addi";     got = dut.DataPath_0.RegFile_0.data[13]; want = 32'd0;         end
        11: begin nm = "bne_pc";   got = dut.DataPath_0.pc;                 want = 32'd52;        end
        12: begin nm = "r0";       got = dut.DataPath_0.RegFile_0.data[0];  want = 32'd0;         end
        13: begin nm = "unk_pc";   got = dut.DataPath_0.pc;                 want = 32'd60;        end
        15: begin nm = "j_pc";     got = dut.DataPath_0.pc;                 want = 32'h40;        end
        16: begin nm = "ori";      got = dut.DataPath_0.RegFile_0.data[14]; want = 32'h1234;      end
        17: begin nm = "sll";      got = dut.DataPath_0.RegFile_0.data[15]; want = 32'd48;        end
        18: begin nm = "nor";      got = dut.DataPath_0.RegFile_0.data[16]; want = 32'hFFFF_FFFF; end
        19: begin nm = "andi";     got = dut.DataPath_0.RegFile_0.data[17]; want = 32'hF0;        end
        20: begin nm = "skip_r20"; got = dut.DataPath_0.RegFile_0.data[20]; want = 32'd20;        end
        default: have = 1'b0;
      endcase
      if (have) begin
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL dir_%s: got %h want %h", nm, got, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // make the in-flight ori observable if it were to commit
    m_reg[14] = 32'd0;
    dut.DataPath_0.RegFile_0.data[14] = 32'd0;
    #2;
    reset = 1'b0;
    m_pc  = RESET_PC;
    #1;
    checks++;
    if (dut.DataPath_0.pc !== RESET_PC) begin
      errors++; $display("FAIL midreset_async_pc: got %h want %h", dut.DataPath_0.pc, RESET_PC);
    end
    @(negedge clock);
    checks++;
    if (dut.DataPath_0.pc !== RESET_PC) begin
      errors++; $display("FAIL midreset_hold_pc: got %h want %h", dut.DataPath_0.pc, RESET_PC);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.DataPath_0.RegFile_0.data[i] !== m_reg[i]) begin
        errors++; $display("FAIL midreset_reg r%0d: got %h want %h", i, dut.DataPath_0.RegFile_0.data[i], m_reg[i]);
      end
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (dut.DataPath_0.pc !== RESET_PC + 32'd4 || dut.DataPath_0.pc !== m_pc) begin
      errors++; $display("FAIL midreset_restart_pc: got %h want %h", dut.DataPath_0.pc, m_pc);
    end
  endtask

  task automatic test_self_modify();
    init_model();
    m_reg[5] = i_ins(6'h08, 5'd0, 5'd9, 16'd77);
    m_mem[0] = i_ins(6'h2B, 5'd0, 5'd5, 16'd8);
    m_mem[2] = i_ins(6'h08, 5'd0, 5'd9, 16'd1);
    reset = 1'b0;
    push_to_dut();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) cycle();
    checks++;
    if (dut.DataPath_0.RegFile_0.data[9] !== 32'd77 || m_reg[9] !== 32'd77) begin
      errors++; $display("FAIL selfmod_r9: got %h want %h", dut.DataPath_0.RegFile_0.data[9], 32'd77);
    end
    checks++;
    if (dut.DataPath_0.pc !== m_pc) begin
      errors++; $display("FAIL selfmod_pc: got %h want %h", dut.DataPath_0.pc, m_pc);
    end
  endtask

  task automatic test_random();
    bit diverged;
    for (int round = 0; round < 4; round++) begin
      init_model();
      for (int i = 1; i < 32; i++)
        m_reg[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
      for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = rand_ins();
      reset = 1'b0;
      push_to_dut();
      @(negedge clock);
      reset = 1'b1;
      diverged = 1'b0;
      for (int s = 0; s < 200 && !diverged; s++) begin
        cycle();
        checks++;
        if (dut.DataPath_0.pc !== m_pc) begin
          errors++; diverged = 1'b1;
          $display("FAIL rand_pc round %0d step %0d: got %h want %h", round, s, dut.DataPath_0.pc, m_pc);
        end
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (dut.DataPath_0.RegFile_0.data[i] !== m_reg[i]) begin
          errors++; $display("FAIL rand_reg round %0d r%0d: got %h want %h", round, i, dut.DataPath_0.RegFile_0.data[i], m_reg[i]);
        end
      end
      for (int i = 0; i < MEM_WORDS; i++) begin
        checks++;
        if (dut.DataPath_0.Memory_0.data[i] !== m_mem[i]) begin
          errors++; $display("FAIL rand_mem round %0d w%0d: got %h want %h", round, i, dut.DataPath_0.Memory_0.data[i], m_mem[i]);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_self_modify();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
